// File: rtl/px_readout_ctrl.sv
// ----------------------------------------------------------------------------
// px_readout_ctrl
//
// Frame sequencer for the pixel array. An accepted start runs one frame:
// ERASE -> EXPOSE -> CONVERT -> (READ_ROW -> HOLD) per row -> DONE.
// The block drives the phase strobes shared by all pixels and the shared ramp
// code used during conversion. Row data is returned over a valid/ready
// handshake, so a slow consumer stalls readout instead of losing rows.
//
// Optional feature macro: PX_CONT_MODE_EN
//   When defined, input `cont` is added. DONE then returns to ERASE when
//   cont=1, re-latching cfg_expose, so frames run back-to-back.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   start       frame request, sampled in IDLE only
//   cfg_expose  exposure length in cycles, latched on start (0 acts as 1)
//   px_bus      row data from the selected row, col0 in the LSBs
//   erase/expose/convert/read  phase strobes, at most one high at a time
//   row_sel     row being read
//   ramp_code   shared ramp/count code, counts only during CONVERT
//   out_data    captured row data, out_row its row index
//   out_valid   out_data valid, out_ready downstream accept
//   cont        continuous-mode request (PX_CONT_MODE_EN only)
//   busy        high in every state except IDLE
//   frame_done  one-cycle pulse at frame end
//
// All outputs are registered.
// ----------------------------------------------------------------------------
module px_readout_ctrl #(
    parameter int N_ROWS    = 2,
    parameter int N_COLS    = 2,
    parameter int DATA_W    = 8,
    parameter int C_ERASE   = 5,
    parameter int C_CONVERT = 255,
    localparam int ROW_W    = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [15:0]                cfg_expose,
    input  logic [N_COLS*DATA_W-1:0]   px_bus,
    output logic                       erase,
    output logic                       expose,
    output logic                       convert,
    output logic                       read,
    output logic [ROW_W-1:0]           row_sel,
    output logic [DATA_W-1:0]          ramp_code,
    output logic [N_COLS*DATA_W-1:0]   out_data,
    output logic [ROW_W-1:0]           out_row,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef PX_CONT_MODE_EN
    input  logic                       cont,
`endif
    output logic                       busy,
    output logic                       frame_done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ERASE    = 3'd1,
        EXPOSE   = 3'd2,
        CONVERT  = 3'd3,
        READ_ROW = 3'd4,
        HOLD     = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam logic [15:0]       ERASE_LAST = 16'(C_ERASE - 1);
    localparam logic [DATA_W-1:0] RAMP_LAST  = DATA_W'(C_CONVERT);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(N_ROWS - 1);

    state_t      state_r;
    logic [15:0] expose_len_r;   // latched exposure, never 0
    logic [15:0] phase_cnt_r;    // cycle counter for ERASE and EXPOSE

    // Frame sequencer: state, phase counters and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            expose_len_r <= 16'd1;
            phase_cnt_r  <= 16'd0;
            erase        <= 1'b0;
            expose       <= 1'b0;
            convert      <= 1'b0;
            read         <= 1'b0;
            row_sel      <= '0;
            ramp_code    <= '0;
            out_data     <= '0;
            out_row      <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        expose_len_r <= (cfg_expose == 16'd0) ? 16'd1 : cfg_expose;
                        phase_cnt_r  <= 16'd0;
                        erase        <= 1'b1;
                        busy         <= 1'b1;
                        state_r      <= ERASE;
                    end else begin
                        state_r      <= IDLE;
                    end
                end
                ERASE: begin
                    if (phase_cnt_r == ERASE_LAST) begin
                        phase_cnt_r <= 16'd0;
                        erase       <= 1'b0;
                        expose      <= 1'b1;
                        state_r     <= EXPOSE;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + 16'd1;
                    end
                end
                EXPOSE: begin
                    if (phase_cnt_r == (expose_len_r - 16'd1)) begin
                        phase_cnt_r <= 16'd0;
                        expose      <= 1'b0;
                        convert     <= 1'b1;
                        ramp_code   <= '0;
                        state_r     <= CONVERT;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + 16'd1;
                    end
                end
                CONVERT: begin
                    // The ramp stops at C_CONVERT, so it never wraps in a frame.
                    if (ramp_code == RAMP_LAST) begin
                        convert   <= 1'b0;
                        ramp_code <= '0;
                        read      <= 1'b1;
                        row_sel   <= '0;
                        state_r   <= READ_ROW;
                    end else begin
                        ramp_code <= ramp_code + DATA_W'(1);
                    end
                end
                READ_ROW: begin
                    // Pixels drive px_bus for the whole read cycle; sample at its end.
                    read      <= 1'b0;
                    out_data  <= px_bus;
                    out_row   <= row_sel;
                    out_valid <= 1'b1;
                    state_r   <= HOLD;
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (row_sel == ROW_LAST) begin
                            row_sel    <= '0;
                            frame_done <= 1'b1;
                            state_r    <= DONE;
                        end else begin
                            row_sel    <= row_sel + ROW_W'(1);
                            read       <= 1'b1;
                            state_r    <= READ_ROW;
                        end
                    end else begin
                        state_r <= HOLD;
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
`ifdef PX_CONT_MODE_EN
                    if (cont) begin
                        expose_len_r <= (cfg_expose == 16'd0) ? 16'd1 : cfg_expose;
                        phase_cnt_r  <= 16'd0;
                        erase        <= 1'b1;
                        state_r      <= ERASE;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
`else
                    busy    <= 1'b0;
                    state_r <= IDLE;
`endif
                end
                default: begin
                    state_r    <= IDLE;
                    erase      <= 1'b0;
                    expose     <= 1'b0;
                    convert    <= 1'b0;
                    read       <= 1'b0;
                    row_sel    <= '0;
                    ramp_code  <= '0;
                    out_valid  <= 1'b0;
                    busy       <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_px_readout_ctrl.sv
// ----------------------------------------------------------------------------
// tb_px_readout_ctrl
//
// Directed bench for px_readout_ctrl with default parameters. Expected row
// transfers are queued when a frame is started and popped as the DUT hands
// them over. Phase lengths, ramp sequence, frame length and frame_done
// count come from the bench's own arithmetic.
// ----------------------------------------------------------------------------
module tb_px_readout_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_expose = 16'd0;
    wire  [15:0] px_bus;
    logic        erase, expose, convert, read;
    logic        row_sel;
    logic [7:0]  ramp_code;
    logic [15:0] out_data;
    logic        out_row;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        cont = 1'b0;
    logic        busy, frame_done;

    logic [15:0] row_data [2];
    logic [23:0] sb_q [$];   // {row[7:0], data[15:0]}

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Pixel array model: the selected row drives the bus only while read is high.
    assign px_bus = read ? row_data[row_sel] : 16'hzzzz;

    px_readout_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_expose (cfg_expose),
        .px_bus     (px_bus),
        .erase      (erase),
        .expose     (expose),
        .convert    (convert),
        .read       (read),
        .row_sel    (row_sel),
        .ramp_code  (ramp_code),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef PX_CONT_MODE_EN
        .cont       (cont),
`endif
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {32'd0, erase, expose, convert, read, row_sel, ramp_code,
                  out_data, out_row, out_valid, busy, frame_done}, 64'd0);
    endtask

    // Compare the handshake output against the queue head; pop on transfer.
    task automatic check_out();
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                chk("out_data", 64'(out_data), 64'(sb_q[0][15:0]));
                chk("out_row",  64'(out_row),  64'(sb_q[0][23:16]));
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    endtask

    // Run one frame from IDLE and check it end to end.
    task automatic run_frame(input logic [15:0] ecfg, input int stall,
                             input logic [15:0] d0, input logic [15:0] d1,
                             input bit poke);
        int n_er = 0, n_ex = 0, n_cv = 0, n_done = 0, n_valid = 0;
        int first = -1, donec = -1, stall_left = stall, rows_seen = 0;
        int exp_ramp = 0;
        int exp_expo;
        exp_expo = (ecfg == 16'd0) ? 1 : int'(ecfg);
        row_data[0] = d0;
        row_data[1] = d1;
        sb_q.push_back({8'd0, d0});
        sb_q.push_back({8'd1, d1});
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        cfg_expose = ecfg;
        start = 1'b1;
        for (int c = 0; c < 2000 && n_done == 0; c++) begin
            @(negedge clk);
            // Mid-frame changes of cfg_expose and start must be ignored.
            cfg_expose = 16'h0BEE;
            start = poke && convert && (ramp_code == 8'd50);
            out_ready = !(stall_left > 0 && out_valid && out_row == 1'b0);
            if (!out_ready) begin
                stall_left--;
                chk("stall_no_read", 64'(read), 64'd0);
            end
            chk("one_hot", 64'(32'(erase) + 32'(expose) + 32'(convert) + 32'(read) <= 1), 64'd1);
            if (erase && first < 0) first = c;
            if (erase) n_er++;
            if (expose) n_ex++;
            if (convert) begin
                chk("ramp_code", 64'(ramp_code), 64'(exp_ramp));
                exp_ramp++;
                n_cv++;
            end else if (ramp_code !== 8'd0) begin
                chk("ramp_idle", 64'(ramp_code), 64'd0);
            end
            if (read) begin
                chk("row_sel", 64'(row_sel), 64'(rows_seen));
                rows_seen++;
            end
            if (out_valid) n_valid++;
            check_out();
            if (frame_done) begin
                n_done++;
                donec = c;
            end
        end
        out_ready = 1'b1;
        start = 1'b0;
        chk("erase_len",   64'(n_er), 64'(5));
        chk("expose_len",  64'(n_ex), 64'(exp_expo));
        chk("convert_len", 64'(n_cv), 64'(256));
        chk("rows_read",   64'(rows_seen), 64'(2));
        chk("valid_cycles", 64'(n_valid), 64'(2 + stall));
        chk("frame_done_cnt", 64'(n_done), 64'(1));
        chk("frame_len", 64'(donec - first + 1), 64'(5 + exp_expo + 256 + 4 + 1 + stall));
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
        chk("busy_after", 64'(busy), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stay_idle", {62'd0, erase, frame_done}, 64'd0);
        end
    endtask

    initial begin
        bit reached;
        int n_done;
        row_data[0] = 16'h0000;
        row_data[1] = 16'h0000;

        // Reset state
        #2;
        chk_all_zero("reset_outputs");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("after_reset_idle");

        // Basic frame, then a stalled frame, then exposure 0 with a stray start
        run_frame(16'd10, 0, 16'hA0B1, 16'hC2D3, 1'b0);
        run_frame(16'd3,  7, 16'h1234, 16'h5678, 1'b0);
        run_frame(16'd0,  0, 16'h9A5C, 16'h3E01, 1'b1);

        // Asynchronous reset in the middle of CONVERT
        row_data[0] = 16'h7777;
        row_data[1] = 16'h8888;
        @(negedge clk);
        cfg_expose = 16'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 1000 && !reached; c++) begin
            @(negedge clk);
            reached = convert && (ramp_code == 8'd100);
        end
        chk("reached_ramp100", 64'(reached), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async_reset_outputs");
        n_done = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (frame_done) n_done++;
        end
        chk("no_partial_done", 64'(n_done), 64'd0);
        chk_all_zero("held_in_reset");
        rst = 1'b1;
        sb_q.delete();
        run_frame(16'd2, 0, 16'h0F0F, 16'hF00F, 1'b0);

`ifdef PX_CONT_MODE_EN
        // Continuous mode: two back-to-back frames, cont dropped in frame 2
        begin
            bit prev_done;
            prev_done = 1'b0;
            n_done = 0;
            row_data[0] = 16'h1111;
            row_data[1] = 16'h2222;
            for (int f = 0; f < 2; f++) begin
                sb_q.push_back({8'd0, 16'h1111});
                sb_q.push_back({8'd1, 16'h2222});
            end
            cont = 1'b1;
            cfg_expose = 16'd2;
            @(negedge clk);
            start = 1'b1;
            for (int c = 0; c < 1500 && n_done < 2; c++) begin
                @(negedge clk);
                start = 1'b0;
                check_out();
                if (prev_done) begin
                    chk("cont_erase_next", 64'(erase), 64'd1);
                    chk("cont_busy", 64'(busy), 64'd1);
                    cont = 1'b0;
                end
                prev_done = frame_done;
                if (frame_done) n_done++;
            end
            chk("cont_done_cnt", 64'(n_done), 64'd2);
            chk("cont_sb_empty", 64'(sb_q.size()), 64'd0);
            @(negedge clk);
            chk("cont_idle_busy", 64'(busy), 64'd0);
            chk("cont_idle_erase", 64'(erase), 64'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
